// File: rtl/err_pos_gen.sv
// Error-position generator: drives the PRNG command port and emits T distinct positions in [0, N).
// Latency: 1 (REQ) + PRNG_WAIT + max(1,k) (CHECK) cycles per candidate, plus the output handshake.
// Backpressure: pos_vld/pos_dat/pos_idx hold until pos_rdy; no PRNG command is issued while stalled.
module err_pos_gen #(
    parameter int N          = 2048,
    parameter int T          = 27,
    parameter int POS_W      = 11,
    parameter int PRNG_TYP_W = 2,
    parameter int PRNG_DAT_W = 32,
    parameter int PRNG_WAIT  = 8,
    parameter int SEED_WAIT  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   seed_vld,
    input  logic [PRNG_DAT_W-1:0]  seed,
    output logic                   busy,
    output logic                   done,
    output logic                   pos_vld,
    output logic [POS_W-1:0]       pos_dat,
    output logic [$clog2(T+1)-1:0] pos_idx,
    input  logic                   pos_rdy,
    output logic [PRNG_TYP_W-1:0]  prng_typ_sel,
    output logic                   prng_t_sel,
    output logic [PRNG_DAT_W-1:0]  prng_t_dat,
    input  logic [PRNG_DAT_W-1:0]  prng_r_dat
);
    localparam int IDX_W   = $clog2(T + 1);
    localparam int CNT_MAX = (PRNG_WAIT > SEED_WAIT) ? PRNG_WAIT : SEED_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int LIM_W   = POS_W + 1;

    // One extra bit on the limit so N == 2^POS_W still compares correctly.
    localparam logic [LIM_W-1:0]      N_LIM      = LIM_W'(N);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(T - 1);
    localparam logic [CNT_W-1:0]      PRNG_LD    = CNT_W'(PRNG_WAIT - 1);
    localparam logic [CNT_W-1:0]      SEED_LD    = CNT_W'(SEED_WAIT - 1);
    localparam logic [PRNG_TYP_W-1:0] TYP_HALT   = PRNG_TYP_W'(0);
    localparam logic [PRNG_TYP_W-1:0] TYP_TRIG   = PRNG_TYP_W'(1);
    localparam logic [PRNG_TYP_W-1:0] TYP_SEED   = PRNG_TYP_W'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED_LD,
        S_SEED_WT,
        S_REQ,
        S_WAIT,
        S_CHECK,
        S_OUT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] k;           // positions accepted so far in this run
    logic [IDX_W-1:0] scan;        // store entry being compared in CHECK
    logic [CNT_W-1:0] cnt;         // shared wait counter for SEED_WT and WAIT
    logic [POS_W-1:0] cand;        // sampled candidate position
    logic             start_pend;  // start that arrived together with seed_vld

    // Store is sized to the index range so every index value selects a real entry.
    logic [POS_W-1:0] store [2**IDX_W];

    logic cand_oor;
    logic cand_hit;
    logic scan_last;

    // Only the random field is meaningful; the rest of the bus is folded away.
    logic unused_r_dat;
    assign unused_r_dat = ^prng_r_dat;

    assign cand_oor  = {1'b0, cand} >= N_LIM;
    assign cand_hit  = (k != '0) && (store[scan] == cand);
    assign scan_last = (k == '0) || (scan == k - 1'b1);

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (seed_vld) begin
                    state_nxt = S_SEED_LD;
                end else if (start || start_pend) begin
                    state_nxt = S_REQ;
                end
            end
            S_SEED_LD: state_nxt = S_SEED_WT;
            S_SEED_WT: begin
                if (cnt == '0) begin
                    state_nxt = S_IDLE;
                end
            end
            S_REQ:  state_nxt = S_WAIT;
            S_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                // Range and duplicate rejects both just re-trigger the PRNG.
                if (cand_oor || cand_hit) begin
                    state_nxt = S_REQ;
                end else if (scan_last) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (pos_rdy) begin
                    state_nxt = (k == LAST_IDX) ? S_DONE : S_REQ;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and run bookkeeping (k, scan pointer, wait counter, candidate).
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            k          <= '0;
            scan       <= '0;
            cnt        <= '0;
            cand       <= '0;
            start_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (seed_vld && start) begin
                        start_pend <= 1'b1;
                    end else if (!seed_vld) begin
                        start_pend <= 1'b0;
                    end
                end
                S_SEED_LD: cnt <= SEED_LD;
                S_REQ:     cnt <= PRNG_LD;
                S_SEED_WT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cand <= prng_r_dat[14 -: POS_W];
                        scan <= '0;
                    end
                end
                S_CHECK: begin
                    if (state_nxt == S_CHECK) begin
                        scan <= scan + 1'b1;
                    end
                end
                S_OUT: begin
                    if (pos_rdy) begin
                        k <= k + 1'b1;
                    end
                end
                S_DONE:  k <= '0;
                default: ;
            endcase
        end
    end

    // Accepted positions are written at the handshake; contents need no reset.
    always_ff @(posedge clk) begin
        if (state == S_OUT && pos_rdy) begin
            store[k] <= cand;
        end
    end

    // Registered outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            pos_vld      <= 1'b0;
            pos_dat      <= '0;
            pos_idx      <= '0;
            prng_typ_sel <= TYP_HALT;
            prng_t_sel   <= 1'b0;
            prng_t_dat   <= '0;
        end else begin
            busy       <= (state_nxt != S_IDLE);
            done       <= (state_nxt == S_DONE);
            pos_vld    <= (state_nxt == S_OUT);
            prng_t_sel <= (state_nxt == S_SEED_LD);
            prng_t_dat <= (state_nxt == S_SEED_LD) ? seed : '0;
            if (state_nxt == S_REQ) begin
                prng_typ_sel <= TYP_TRIG;
            end else if (state_nxt == S_SEED_LD) begin
                prng_typ_sel <= TYP_SEED;
            end else begin
                prng_typ_sel <= TYP_HALT;
            end
            if (state == S_CHECK && state_nxt == S_OUT) begin
                pos_dat <= cand;
                pos_idx <= k;
            end
        end
    end

endmodule

// File: tb/tb_err_pos_gen.sv
// Bench for err_pos_gen: stub PRNG that answers only in the sampling window, scoreboard model.
// Latency: runs are bounded by cycle budgets; each wait that expires is reported as a failure.
// Backpressure: pos_rdy is driven always-high, randomly, or held low for stall checks.
module tb_err_pos_gen;
    localparam int N_P    = 1500;
    localparam int T_P    = 3;
    localparam int POS_W  = 11;
    localparam int IDX_W  = $clog2(T_P + 1);
    localparam int PW     = 8;
    localparam int JUNK_F = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             seed_vld;
    logic [31:0]      seed;
    logic             busy;
    logic             done;
    logic             pos_vld;
    logic [POS_W-1:0] pos_dat;
    logic [IDX_W-1:0] pos_idx;
    logic             pos_rdy;
    logic [1:0]       prng_typ_sel;
    logic             prng_t_sel;
    logic [31:0]      prng_t_dat;
    logic [31:0]      prng_r_dat;

    err_pos_gen #(
        .N(N_P), .T(T_P), .POS_W(POS_W), .PRNG_TYP_W(2), .PRNG_DAT_W(32),
        .PRNG_WAIT(PW), .SEED_WAIT(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .seed_vld(seed_vld), .seed(seed),
        .busy(busy), .done(done), .pos_vld(pos_vld), .pos_dat(pos_dat), .pos_idx(pos_idx),
        .pos_rdy(pos_rdy), .prng_typ_sel(prng_typ_sel), .prng_t_sel(prng_t_sel),
        .prng_t_dat(prng_t_dat), .prng_r_dat(prng_r_dat)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int trig_at = -100;
    logic [31:0] pend;
    int prng_q[$];
    int src_q[$];
    int exp_q[$];
    int exp_used;
    int got_dat[$];
    int got_idx[$];
    int cmd_log[$];
    int trig_cnt, seed_cnt, done_cnt, busy_cnt;
    int held_viol = 0, sel_viol = 0, stall_viol = 0;
    logic [31:0] seed_seen;
    int rdy_mode = 0;
    logic prev_vld = 1'b0, prev_acc = 1'b0;
    logic [1:0] prev_typ = 2'd0;
    logic [POS_W-1:0] prev_dat;
    logic [IDX_W-1:0] prev_idx;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_word(input int f);
        logic [31:0] w;
        w = $urandom() & 32'hFFFF_800F;
        w[14:4] = f[10:0];
        return w;
    endfunction

    // Reference: walk the samples in order, keep those in range and not seen yet, stop at T.
    task automatic build_expect();
        exp_q.delete();
        exp_used = 0;
        for (int i = 0; i < src_q.size() && exp_q.size() < T_P; i++) begin
            bit dup;
            dup = 1'b0;
            exp_used++;
            foreach (exp_q[j]) if (exp_q[j] == src_q[i]) dup = 1'b1;
            if (src_q[i] < N_P && !dup) exp_q.push_back(src_q[i]);
        end
        prng_q = src_q;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        trig_cnt = 0; seed_cnt = 0; done_cnt = 0; busy_cnt = 0;
        got_dat.delete(); got_idx.delete(); cmd_log.delete();
        seed_seen = '0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            tick(1);
            n++;
        end
        check_eq({tag, "_done_seen"}, 64'(done_cnt != 0), 1);
    endtask

    task automatic check_run(input string tag);
        tick(30);
        check_eq({tag, "_npos"}, got_dat.size(), exp_q.size());
        for (int i = 0; i < got_dat.size() && i < exp_q.size(); i++) begin
            check_eq($sformatf("%s_pos%0d", tag, i), got_dat[i], exp_q[i]);
            check_eq($sformatf("%s_idx%0d", tag, i), got_idx[i], i);
        end
        check_eq({tag, "_trig"}, trig_cnt, exp_used);
        check_eq({tag, "_done_cnt"}, done_cnt, 1);
        check_eq({tag, "_busy_end"}, busy, 0);
    endtask

    task automatic run_list(input string tag);
        clear_counters();
        build_expect();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(tag);
        check_run(tag);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Stub PRNG: the sample is valid only in the cycle PW cycles after the trigger pulse.
    initial begin
        prng_r_dat = mk_word(JUNK_F);
        pend = mk_word(JUNK_F);
        forever begin
            @(negedge clk);
            if (!rst && prng_typ_sel == 2'd1) begin
                trig_at = cyc;
                pend = (prng_q.size() > 0) ? mk_word(prng_q.pop_front()) : mk_word(JUNK_F);
            end
            prng_r_dat = (cyc == trig_at + PW) ? pend : mk_word(JUNK_F);
        end
    end

    initial begin
        pos_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       pos_rdy = 1'b1;
                1:       pos_rdy = 1'($urandom_range(0, 1));
                default: pos_rdy = 1'b0;
            endcase
        end
    end

    // Protocol monitor: command pulses, seed strobe, handshake log and stall stability.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_vld = 1'b0;
            prev_acc = 1'b0;
            prev_typ = 2'd0;
        end else begin
            if (prng_typ_sel != 2'd0 && prev_typ != 2'd0) held_viol++;
            if (prng_typ_sel == 2'd1) begin
                trig_cnt++;
                cmd_log.push_back(1);
            end
            if (prng_typ_sel == 2'd2) begin
                seed_cnt++;
                seed_seen = prng_t_dat;
                cmd_log.push_back(2);
                if (!prng_t_sel) sel_viol++;
            end
            if (prng_t_sel && prng_typ_sel != 2'd2) sel_viol++;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (prev_vld && !prev_acc &&
                (!pos_vld || pos_dat != prev_dat || pos_idx != prev_idx)) stall_viol++;
            if (pos_vld && prng_typ_sel != 2'd0) stall_viol++;
            if (pos_vld && pos_rdy) begin
                got_dat.push_back(int'(pos_dat));
                got_idx.push_back(int'(pos_idx));
            end
            prev_vld = pos_vld;
            prev_acc = pos_vld && pos_rdy;
            prev_dat = pos_dat;
            prev_idx = pos_idx;
            prev_typ = prng_typ_sel;
        end
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; seed_vld = 1'b0; seed = '0;
        clear_counters();
        tick(3);
        check_eq("reset_outs", {busy, done, pos_vld, pos_dat, pos_idx, prng_typ_sel,
                                prng_t_sel, prng_t_dat}, 0);
        rst = 1'b0;
        tick(2);

        // Seed load: one command cycle, three halt cycles, back to idle.
        clear_counters();
        seed = 32'h0000_3039;
        seed_vld = 1'b1;
        tick(1);
        seed_vld = 1'b0;
        seed = '0;
        tick(10);
        check_eq("seed_pulses", seed_cnt, 1);
        check_eq("seed_dat", seed_seen, 32'h0000_3039);
        check_eq("seed_busy_cycles", busy_cnt, 4);
        check_eq("seed_no_trig", trig_cnt, 0);
        check_eq("seed_idle", busy, 0);

        src_q = '{5, 7, 1};
        run_list("basic");
        src_q = '{5, 5, 7, 1};
        run_list("dup");
        src_q = '{2047, 93, 1500, 1499, 0};
        run_list("range");

        // Back-pressure: hold pos_rdy low for 20 cycles; stray start/seed_vld must be ignored.
        clear_counters();
        src_q = '{300, 301, 302};
        build_expect();
        rdy_mode = 2;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        n = 0;
        while (!pos_vld && n < 200) begin
            tick(1);
            n++;
        end
        check_eq("bp_vld_seen", pos_vld, 1);
        start = 1'b1; seed_vld = 1'b1; seed = 32'hDEAD_BEEF;
        tick(1);
        start = 1'b0; seed_vld = 1'b0; seed = '0;
        tick(19);
        check_eq("bp_vld_held", pos_vld, 1);
        check_eq("bp_dat", pos_dat, exp_q[0]);
        check_eq("bp_idx", pos_idx, 0);
        check_eq("bp_one_trig", trig_cnt, 1);
        rdy_mode = 0;
        wait_done("bp");
        check_run("bp");
        check_eq("bp_no_seed", seed_cnt, 0);

        // Reset while waiting on the PRNG, then seed and start in the same cycle.
        clear_counters();
        src_q = '{10, 20, 30};
        build_expect();
        rdy_mode = 1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        n = 0;
        while (trig_cnt == 0 && n < 50) begin
            tick(1);
            n++;
        end
        tick(3);
        rst = 1'b1;
        tick(1);
        check_eq("rst_mid_outs", {busy, done, pos_vld, pos_dat, pos_idx, prng_typ_sel,
                                  prng_t_sel, prng_t_dat}, 0);
        check_eq("rst_mid_no_done", done_cnt, 0);
        rst = 1'b0;
        clear_counters();
        src_q = '{40, 50, 60};
        build_expect();
        seed = 32'h1234_5678;
        seed_vld = 1'b1;
        start = 1'b1;
        tick(1);
        seed_vld = 1'b0;
        start = 1'b0;
        seed = '0;
        wait_done("rst_seed");
        check_run("rst_seed");
        check_eq("rst_cmd_first", (cmd_log.size() > 0) ? cmd_log[0] : -1, 2);
        check_eq("rst_cmd_second", (cmd_log.size() > 1) ? cmd_log[1] : -1, 1);
        check_eq("rst_seed_dat", seed_seen, 32'h1234_5678);

        // Randomized runs with random back-pressure, frequent duplicates and out-of-range samples.
        for (int r = 0; r < 8; r++) begin
            src_q.delete();
            for (int i = 0; i < 40; i++) begin
                int f;
                f = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 2047);
                if (f == JUNK_F) f = 256;
                src_q.push_back(f);
            end
            rdy_mode = 1;
            run_list($sformatf("rand%0d", r));
        end
        rdy_mode = 0;

        check_eq("held_cmd", held_viol, 0);
        check_eq("seed_strobe", sel_viol, 0);
        check_eq("stall_stable", stall_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/err_pos_gen.md
# err_pos_gen

Error-position generator for the Niederreiter encryption path. It is the requesting end of the PRNG command interface: it loads a seed, triggers generation runs, and samples the 15-bit random output. From those samples it builds T distinct error positions in [0, N). Positions go out one at a time over a valid/ready handshake to the error-vector / syndrome datapath.

## Interface
Parameters:
- N, 2048, code length; positions must be < N (N ≤ 2^POS_W)
- T, 27, error weight; number of distinct positions produced per run
- POS_W, 11, position width (POS_W ≤ 15)
- PRNG_TYP_W, 2, width of the PRNG command field
- PRNG_DAT_W, 32, width of PRNG seed/output bus
- PRNG_WAIT, 8, cycles from trigger pulse to sampling `prng_r_dat`
- SEED_WAIT, 3, cycles after seed command before the next command

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- start  in  1  begin a T-position run (pulse, sampled in IDLE only)
- seed_vld  in  1  load `seed` into the PRNG (pulse, sampled in IDLE only)
- seed  in  PRNG_DAT_W  seed value
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the T-th position is accepted
- pos_vld  out  1  position valid
- pos_dat  out  POS_W  position value
- pos_idx  out  $clog2(T+1)  index (0..T-1) of the presented position
- pos_rdy  in  1  downstream accepts position
- prng_typ_sel  out  PRNG_TYP_W  0 halt, 1 trigger, 2 seed update
- prng_t_sel  out  1  seed-data strobe
- prng_t_dat  out  PRNG_DAT_W  seed data
- prng_r_dat  in  PRNG_DAT_W  PRNG output; random field is bits [14:0]

## Operation
- FSM states: IDLE, SEED_LD, SEED_WT, REQ, WAIT, CHECK, OUT, DONE.
- IDLE:
  - seed_vld → SEED_LD.
  - Else start → REQ.
  - seed_vld and start in the same cycle → seed load first. The start request is latched and taken on return to IDLE.
- SEED_LD (1 cycle): prng_typ_sel=2, prng_t_sel=1, prng_t_dat=seed (captured at seed_vld). → SEED_WT.
- SEED_WT: prng_typ_sel=0, prng_t_sel=0 for SEED_WAIT cycles. → IDLE.
- REQ (1 cycle): prng_typ_sel=1. → WAIT.
- WAIT: prng_typ_sel=0 for PRNG_WAIT cycles. On the last cycle, capture cand = prng_r_dat[14 -: POS_W]. → CHECK.
- CHECK:
  - cand ≥ N → reject, → REQ.
  - Otherwise compare cand against stored entries 0..k-1, one entry per cycle (k = positions accepted so far).
  - Any match → reject, → REQ.
  - Scan complete with no match, or k=0 → OUT.
- OUT: pos_vld=1, pos_dat=cand, pos_idx=k. Both are held stable until pos_rdy.
  - On pos_vld&pos_rdy: store cand at entry k, k←k+1.
  - If the new k=T → DONE, else → REQ.
- DONE (1 cycle): done=1, k←0. → IDLE.
- No retry limit; rejection simply re-triggers the PRNG.
- prng_typ_sel is 1 or 2 for exactly one cycle per command, and 0 otherwise. The PRNG re-triggers on a held non-zero command, so a held command is forbidden.
- start and seed_vld outside IDLE are ignored and not latched, except the same-cycle case above.
- Reset: outputs go to 0 at the next edge (busy, done, pos_vld, pos_dat, pos_idx, prng_typ_sel, prng_t_sel, prng_t_dat). State→IDLE, k=0, latched start cleared. Position store contents are don't-care. Reset mid-run abandons the run with no done pulse.

## Timing
- All outputs are registered.
- start seen in IDLE at edge 0 → REQ with prng_typ_sel=1 after edge 1. The sample is captured PRNG_WAIT cycles later.
- Per accepted position, minimum cycles = 1 (REQ) + PRNG_WAIT + max(1, k) (CHECK) + 1 (OUT, if pos_rdy=1).
- Seed load: SEED_LD + SEED_WAIT = 4 cycles by default, then IDLE.
- done asserts the cycle after the final handshake; busy drops the cycle after done.
- pos_vld may stay high indefinitely under back-pressure with no change to pos_dat or pos_idx.

## Test plan
- Seed: seed_vld with seed=0x00003039 in IDLE → exactly one cycle with prng_typ_sel=2, prng_t_sel=1, prng_t_dat=0x00003039. Then 3 cycles at typ=0, busy=0 afterwards.
- Basic run, stub PRNG, T=3, N=2048: stub returns 0x0050, 0x0070, 0x0010 → positions 5, 7, 1 with pos_idx 0, 1, 2. Exactly 3 typ=1 pulses, each 8 cycles apart from its sample. done pulses once.
- Duplicate rejection: stub returns 0x0050, 0x0050, 0x0070 → outputs 5, 7 only. 3 trigger pulses for 2 positions.
- Range rejection, N=1500: stub returns 0x7FF0 (2047), then 0x05D0 (93) → 93 only. 2047 is never presented.
- Back-pressure: pos_rdy low for 20 cycles while pos_vld=1 → pos_dat and pos_idx constant, no new prng_typ_sel pulse. Run completes after pos_rdy rises.
- Reset in WAIT mid-run, then start with seed_vld simultaneously → all outputs 0 after the reset edge. Seed command precedes the first trigger, and a fresh run yields pos_idx starting at 0.
